// File: rtl/nios_accelerometer_fir_pkg.sv
// Shared register map and bit positions for the accelerometer FIR sample feeder.
package nios_accelerometer_fir_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 12;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;

endpackage

// File: rtl/nios_accelerometer_sfifo.sv
// Synchronous show-ahead FIFO; the head entry is presented combinationally.
module nios_accelerometer_sfifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              push_ok
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              pop_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop frees the slot a full-FIFO push needs, so the two may share an edge.
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & ~flush & (~full | pop_ok);

    // Gated so the stream sees zero when nothing is queued (including after reset).
    assign rd_data = empty ? '0 : mem[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem[tail] <= push_data;
    end

endmodule

// File: rtl/nios_accelerometer_fir_sample_feeder.sv
// Avalon-MM slave feeding software-written accelerometer samples to the FIR stream.
module nios_accelerometer_fir_sample_feeder
    import nios_accelerometer_fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic              wr;
    logic              wr_data;
    logic              wr_status;
    logic              wr_control;
    logic              flush;
    logic              pop;
    logic              push_ok;
    logic              overflow;
    logic              en;
    logic              ovf;
    logic [DATA_W-1:0] last_sample;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              unused_writedata;

    assign wr         = chipselect & ~write_n;
    assign wr_data    = wr & (address == ADDR_DATA);
    assign wr_status  = wr & (address == ADDR_STATUS);
    assign wr_control = wr & (address == ADDR_CONTROL);
    assign flush      = wr_control & writedata[CTRL_FLUSH];

    assign out_valid = en & ~empty;
    assign pop       = out_valid & out_ready;
    assign overflow  = wr_data & full & ~pop;

    assign unused_writedata = ^writedata;

    nios_accelerometer_sfifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_data),
        .pop       (pop),
        .flush     (flush),
        .push_data (writedata[DATA_W-1:0]),
        .rd_data   (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .push_ok   (push_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            en          <= 1'b0;
            ovf         <= 1'b0;
            last_sample <= '0;
        end else begin
            if (wr_control) en <= writedata[CTRL_EN];
            if (push_ok)    last_sample <= writedata[DATA_W-1:0];
            // A fresh overflow outranks a W1C clear landing on the same edge.
            if (overflow)
                ovf <= 1'b1;
            else if (wr_status && writedata[ST_OVF])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = 32'(last_sample);
            ADDR_STATUS: begin
                readdata[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(count);
                readdata[ST_OVF]   = ovf;
                readdata[ST_FULL]  = full;
                readdata[ST_EMPTY] = empty;
            end
            ADDR_CONTROL: readdata[CTRL_EN] = en;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_accelerometer_fir_sample_feeder.sv
// Directed and randomized bench checking the feeder against a queue-based model.
module tb_nios_accelerometer_fir_sample_feeder;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    always #5 clk = ~clk;

    nios_accelerometer_fir_sample_feeder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] q[$];
    logic              m_en;
    logic              m_ovf;
    logic [DATA_W-1:0] m_last;
    bit                chk_on = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a)
            2'd0: r = 32'(m_last);
            2'd1: r = (32'(q.size()) << 4) | (32'(m_ovf) << 2)
                    | (32'(q.size() == DEPTH) << 1) | 32'(q.size() == 0);
            2'd2: r = 32'(m_en);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic drive(input logic rst, input logic cs, input logic wn,
                         input logic [1:0] a, input logic [31:0] wd, input logic rdy);
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        out_ready  = rdy;
        #1;
    endtask

    // Compare outputs for the current inputs, advance the model, then clock once.
    task automatic step();
        logic              mv;
        logic [DATA_W-1:0] md;
        bit                wr;
        bit                pop;
        mv = m_en && (q.size() != 0);
        md = (q.size() != 0) ? q[0] : '0;
        if (chk_on) begin
            check_eq("out_valid", 32'(out_valid), 32'(mv));
            check_eq("out_data", 32'(out_data), 32'(md));
            check_eq("readdata", readdata, model_rd(address));
        end
        if (reset) begin
            q.delete();
            m_en   = 1'b0;
            m_ovf  = 1'b0;
            m_last = '0;
        end else begin
            wr  = chipselect && !write_n;
            pop = mv && out_ready;
            if (wr && address == 2'd2) m_en = writedata[0];
            if (wr && address == 2'd2 && writedata[1]) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (wr && address == 2'd0) begin
                    if (q.size() < DEPTH) begin
                        q.push_back(writedata[DATA_W-1:0]);
                        m_last = writedata[DATA_W-1:0];
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (wr && address == 2'd1 && writedata[2]) m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_on = 1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd, input logic rdy);
        drive(1'b0, 1'b1, 1'b0, a, wd, rdy);
        step();
    endtask

    task automatic idle(input logic [1:0] a, input logic rdy);
        drive(1'b0, 1'b1, 1'b1, a, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] wd;
        logic [1:0]  a;
        int          r;

        // Reset and idle register values
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
        step();
        step();
        idle(2'd1, 1'b0);
        check_eq("rst_status", readdata, 32'h0000_0001);
        check_eq("rst_valid", 32'(out_valid), 32'h0);
        step();
        idle(2'd2, 1'b0);
        check_eq("rst_control", readdata, 32'h0);
        step();

        // Two samples, stalled then streamed back to back
        wr_reg(2'd2, 32'h1, 1'b0);
        wr_reg(2'd0, 32'h1234, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h5678, 1'b0);
        check_eq("first_valid", 32'(out_valid), 32'h1);
        check_eq("first_data", 32'(out_data), 32'h1234);
        step();
        idle(2'd1, 1'b0);
        check_eq("count2", readdata, 32'h0000_0020);
        step();
        idle(2'd1, 1'b1);
        check_eq("pop_a", 32'(out_data), 32'h1234);
        step();
        idle(2'd1, 1'b1);
        check_eq("pop_b", 32'(out_data), 32'h5678);
        step();
        idle(2'd1, 1'b1);
        check_eq("drained", 32'(out_valid), 32'h0);
        step();

        // Overflow with the stream disabled
        wr_reg(2'd2, 32'h0, 1'b0);
        for (int i = 1; i <= 9; i++) wr_reg(2'd0, 32'(i), 1'b0);
        idle(2'd1, 1'b0);
        check_eq("ovf_status", readdata, 32'h0000_0086);
        step();
        idle(2'd0, 1'b0);
        check_eq("ovf_last", readdata, 32'h8);
        step();
        wr_reg(2'd2, 32'h1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            idle(2'd1, 1'b1);
            step();
        end

        // Push into a full FIFO while it pops
        wr_reg(2'd1, 32'h4, 1'b0);
        for (int i = 1; i <= 8; i++) wr_reg(2'd0, 32'(16 * i), 1'b0);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'hAAAA, 1'b1);
        step();
        idle(2'd1, 1'b0);
        check_eq("full_pop_push", readdata, 32'h0000_0082);
        step();
        for (int i = 0; i < 10; i++) begin
            idle(2'd0, 1'b1);
            step();
        end

        // Flush keeps ovf, takes en from the same word, then W1C
        wr_reg(2'd2, 32'h0, 1'b0);
        for (int i = 0; i < 9; i++) wr_reg(2'd0, 32'h100 + 32'(i), 1'b0);
        wr_reg(2'd2, 32'h3, 1'b0);
        idle(2'd1, 1'b1);
        check_eq("flush_status", readdata, 32'h0000_0005);
        check_eq("flush_valid", 32'(out_valid), 32'h0);
        step();
        idle(2'd2, 1'b0);
        check_eq("flush_en", readdata, 32'h1);
        step();
        wr_reg(2'd1, 32'h4, 1'b0);
        idle(2'd1, 1'b0);
        check_eq("w1c", readdata, 32'h0000_0001);
        step();

        // Reset mid-burst
        for (int i = 0; i < 5; i++) wr_reg(2'd0, 32'h5A0 + 32'(i), 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
        step();
        idle(2'd1, 1'b1);
        check_eq("rst_mid_status", readdata, 32'h0000_0001);
        check_eq("rst_mid_valid", 32'(out_valid), 32'h0);
        step();
        wr_reg(2'd2, 32'h1, 1'b1);
        idle(2'd0, 1'b1);
        check_eq("rst_mid_stale", 32'(out_valid), 32'h0);
        step();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            r  = int'($urandom_range(0, 99));
            a  = (r < 60) ? 2'd0 : (r < 80) ? 2'd1 : (r < 95) ? 2'd2 : 2'd3;
            wd = $urandom;
            if (a == 2'd2) begin
                wd[1] = ($urandom_range(0, 9) == 0);
                wd[0] = ($urandom_range(0, 3) != 0);
            end
            drive(($urandom_range(0, 249) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 2) == 0),
                  a, wd,
                  ($urandom_range(0, 2) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
